// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause/mip,
// optional mtval under `TRAP_CSR_MTVAL_EN`).
// Ports: CLK/RST (async, active-high) and MEM_WAIT stall.
// IRQ_EXT/IRQ_TIMER/IRQ_SOFT interrupt lines.
// CSR_* registered read/write port.
// TRAP_* commit and MRET inputs.
// MRET_PC, TRAP_VEC_*, INT_* trap-unit outputs.
module trap_csr #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] MTVEC_RST   = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        IRQ_EXT,
    input  logic        IRQ_TIMER,
    input  logic        IRQ_SOFT,
    input  logic        CSR_RDEN,
    input  logic        CSR_WREN,
    input  logic [11:0] CSR_ADDR,
    input  logic [31:0] CSR_WDATA,
    output logic [31:0] CSR_RDATA,
    output logic        CSR_RVALID,
    input  logic        TRAP_EN,
    input  logic        TRAP_IS_INT,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_VAL,
    input  logic        MRET,
    output logic [31:0] MRET_PC,
    output logic [1:0]  TRAP_VEC_MODE,
    output logic [31:0] TRAP_VEC_BASE,
    output logic        INT_ALLOW,
    output logic        INT_EN,
    output logic [3:0]  INT_CODE
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {S_RUN, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mie_bit_q, mie_bit_d;
    logic          mpie_q, mpie_d;
    logic [31:0]   mie_q, mie_d;
    logic [31:0]   mtvec_q, mtvec_d;
    logic [31:0]   mscratch_q, mscratch_d;
    logic [31:0]   mepc_q, mepc_d;
    logic [31:0]   mcause_q, mcause_d;
    logic [1:0]    sync_q, sync_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
`ifdef TRAP_CSR_MTVAL_EN
    logic [31:0]   mtval_q, mtval_d;
`endif

    logic [31:0] mstatus_rd, mip, pend;
    logic        trap_go, mret_go, csr_we;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
    assign mip = {20'b0, sync_q[1], 3'b0, IRQ_TIMER, 3'b0, IRQ_SOFT, 3'b0};
    assign pend = mip & mie_q;

    // Trap beats MRET beats CSR write; losers are dropped entirely.
    assign trap_go = (state_q == S_RUN) && TRAP_EN && !MEM_WAIT;
    assign mret_go = MRET && !MEM_WAIT && !trap_go;
    assign csr_we  = CSR_WREN && !MEM_WAIT && !trap_go && !mret_go;

    assign CSR_RDATA     = rdata_q;
    assign CSR_RVALID    = rvalid_q;
    assign MRET_PC       = mepc_q;
    assign TRAP_VEC_MODE = mtvec_q[1:0];
    assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
    assign INT_ALLOW     = mie_bit_q && (state_q == S_RUN);
    assign INT_EN        = |pend;

    // Priority MEI > MSI > MTI.
    always_comb begin
        INT_CODE = 4'd0;
        if (pend[11])     INT_CODE = 4'd11;
        else if (pend[3]) INT_CODE = 4'd3;
        else if (pend[7]) INT_CODE = 4'd7;
    end

    // Read mux sees pre-write register values, so read+write returns old data.
    always_comb begin
        rdata_d  = 32'h0;
        rvalid_d = 1'b0;
        if (CSR_RDEN) begin
            rvalid_d = 1'b1;
            case (CSR_ADDR)
                12'h300: rdata_d = mstatus_rd;
                12'h304: rdata_d = mie_q;
                12'h305: rdata_d = mtvec_q;
                12'h340: rdata_d = mscratch_q;
                12'h341: rdata_d = mepc_q;
                12'h342: rdata_d = mcause_q;
                12'h344: rdata_d = mip;
`ifdef TRAP_CSR_MTVAL_EN
                12'h343: rdata_d = mtval_q;
`endif
                default: rvalid_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        sync_d     = {sync_q[0], IRQ_EXT};
`ifdef TRAP_CSR_MTVAL_EN
        mtval_d    = mtval_q;
`endif
        if (state_q == S_HOLD) begin
            if (cnt_q == '0) state_d = S_RUN;
            else             cnt_d   = cnt_q - 1'b1;
        end
        if (trap_go) begin
            state_d   = S_HOLD;
            cnt_d     = CW'(HOLD_CYCLES - 1);
            mepc_d    = TRAP_PC & ~32'h3;
            mcause_d  = {TRAP_IS_INT, 27'b0, TRAP_CODE[3:0]};
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
`ifdef TRAP_CSR_MTVAL_EN
            mtval_d   = TRAP_IS_INT ? 32'h0 : TRAP_VAL;
`endif
        end else if (mret_go) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (csr_we) begin
            case (CSR_ADDR)
                12'h300: begin
                    mie_bit_d = CSR_WDATA[3];
                    mpie_d    = CSR_WDATA[7];
                end
                12'h304: mie_d      = CSR_WDATA & 32'h0000_0888;
                12'h305: mtvec_d    = CSR_WDATA & 32'hFFFF_FFFD;
                12'h340: mscratch_d = CSR_WDATA;
                12'h341: mepc_d     = CSR_WDATA & ~32'h3;
                12'h342: mcause_d   = CSR_WDATA & 32'h8000_000F;
`ifdef TRAP_CSR_MTVAL_EN
                12'h343: mtval_d    = CSR_WDATA;
`endif
                default: ;
            endcase
        end
    end

`ifndef TRAP_CSR_MTVAL_EN
    logic unused_trap_val;
    assign unused_trap_val = ^TRAP_VAL;
`endif
    logic unused_code;
    assign unused_code = ^TRAP_CODE[31:4];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            sync_q     <= 2'b00;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
`ifdef TRAP_CSR_MTVAL_EN
            mtval_q    <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            sync_q     <= sync_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef TRAP_CSR_MTVAL_EN
            mtval_q    <= mtval_d;
`endif
        end
    end

endmodule
